demo_layer_renderer: RTL and testbench

Per-pixel overlay renderer for the retro console demo screen. It takes the VGA controller's scan position and produces three independent 1-bit layer masks plus their merged mask, each registered one clock after the coordinates:
- a fixed "HELLO" text string;
- a movable 16x16 diamond sprite;
- a wireframe cube whose depth direction is selected by `rotation`.

It sits between `vga_controller` and the colour/palette stage.

---
 rtl/demo_layer_renderer.sv | 198 +++++++++++++++++++
 tb/tb_demo_layer_renderer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demo_layer_renderer.sv
// -----------------------------------------------------------------------------
// demo_layer_renderer
//
// Per-pixel overlay renderer for the demo screen. For every scan position it
// decides whether the pixel belongs to one of three 1-bit layers and registers
// the result one clock later:
//   - a fixed "HELLO" string drawn from an 8x8 font,
//   - a 16x16 diamond sprite whose top-left corner follows sprite_x/sprite_y,
//   - a wireframe cube (front square, back square, four corner connectors)
//     whose depth direction is chosen by rotation.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-high reset (clears all outputs)
//   x_pos/y_pos  current scan column/row from the VGA controller
//   display_on   visible-area flag; when low all outputs go to 0
//   sprite_x/_y  sprite top-left corner, used as presented each cycle
//   rotation     cube depth direction: 0 (+D,-D) 1 (+D,+D) 2 (-D,+D) 3 (-D,-D)
//   text_pixel   text layer mask        (registered, latency 1)
//   sprite_pixel sprite layer mask      (registered, latency 1)
//   vector_pixel cube layer mask        (registered, latency 1)
//   pixel_out    OR of the three masks  (registered, latency 1)
// -----------------------------------------------------------------------------
module demo_layer_renderer #(
   parameter int TEXT_X = 16,
   parameter int TEXT_Y = 16,
   parameter int CUBE_X = 480,
   parameter int CUBE_Y = 240,
   parameter int CUBE_H = 40,
   parameter int CUBE_D = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       display_on,
   input  logic [9:0] sprite_x,
   input  logic [9:0] sprite_y,
   input  logic [1:0] rotation,
   output logic       text_pixel,
   output logic       sprite_pixel,
   output logic       vector_pixel,
   output logic       pixel_out
);

   // All geometry is done on 12-bit signed values so that negative offsets
   // (left of / above an origin) never wrap.
   localparam logic signed [11:0] TX0 = 12'(TEXT_X);
   localparam logic signed [11:0] TY0 = 12'(TEXT_Y);
   localparam logic signed [11:0] FL  = 12'(CUBE_X - CUBE_H);
   localparam logic signed [11:0] FR  = 12'(CUBE_X + CUBE_H);
   localparam logic signed [11:0] FT  = 12'(CUBE_Y - CUBE_H);
   localparam logic signed [11:0] FB  = 12'(CUBE_Y + CUBE_H);
   localparam logic signed [11:0] DD  = 12'(CUBE_D);

   // Font row lookup. Row 0 sits in the most significant byte; bit 7 of the
   // returned byte is the leftmost pixel of the glyph.
   function automatic logic [7:0] glyph_row(input logic [2:0] ch, input logic [2:0] row);
      logic [63:0] g;
      case (ch)
         3'd0:       g = 64'h6666_667E_6666_6600; // H
         3'd1:       g = 64'h7E60_607C_6060_7E00; // E
         3'd2, 3'd3: g = 64'h6060_6060_6060_7E00; // L
         3'd4:       g = 64'h3C66_6666_6666_3C00; // O
         default:    g = 64'h0;
      endcase
      // ~row == 7-row for a 3-bit row index
      return g[{~row, 3'b000} +: 8];
   endfunction

   // Diamond test inside the 16x16 sprite box. For u<8 the distance 7-u is
   // simply ~u[2:0]; for u>=8 the distance u-8 is u[2:0].
   function automatic logic diamond_hit(input logic [3:0] u, input logic [3:0] v);
      logic [2:0] a;
      logic [2:0] b;
      a = u[3] ? u[2:0] : ~u[2:0];
      b = v[3] ? v[2:0] : ~v[2:0];
      return ({1'b0, a} + {1'b0, b}) <= 4'd7;
   endfunction

   // One-pixel outline of the axis-aligned square [l,r] x [t,b], inclusive.
   function automatic logic on_outline(input logic signed [11:0] x,
                                       input logic signed [11:0] y,
                                       input logic signed [11:0] l,
                                       input logic signed [11:0] r,
                                       input logic signed [11:0] t,
                                       input logic signed [11:0] b);
      return (((x == l) || (x == r)) && (y >= t) && (y <= b)) ||
             (((y == t) || (y == b)) && (x >= l) && (x <= r));
   endfunction

   // 45-degree connector leaving corner (px,py). Multiplying by the sign of
   // the depth offset is done by choosing the subtraction order instead.
   function automatic logic on_connector(input logic signed [11:0] x,
                                         input logic signed [11:0] y,
                                         input logic signed [11:0] px,
                                         input logic signed [11:0] py,
                                         input logic               neg_x,
                                         input logic               neg_y,
                                         input logic signed [11:0] d);
      logic signed [11:0] ddx;
      logic signed [11:0] ddy;
      ddx = neg_x ? (px - x) : (x - px);
      ddy = neg_y ? (py - y) : (y - py);
      return (ddx == ddy) && !ddx[11] && (ddx <= d);
   endfunction

   logic signed [11:0] xs;
   logic signed [11:0] ys;
   logic signed [11:0] tx;
   logic signed [11:0] ty;
   logic               text_in;
   logic [7:0]         text_row;

   logic [10:0]        spr_x_end;
   logic [10:0]        spr_y_end;
   logic               spr_in;
   logic [3:0]         spr_u;
   logic [3:0]         spr_v;

   logic               neg_x;
   logic               neg_y;
   logic signed [11:0] ox;
   logic signed [11:0] oy;

   logic text_d;
   logic sprite_d;
   logic vector_d;
   logic pixel_d;
   logic text_q;
   logic sprite_q;
   logic vector_q;
   logic pixel_q;

   assign xs = {2'b00, x_pos};
   assign ys = {2'b00, y_pos};

   // Text layer: 5 characters of 8x8 starting at the text origin
   assign tx       = xs - TX0;
   assign ty       = ys - TY0;
   assign text_in  = !tx[11] && (tx < 12'sd40) && !ty[11] && (ty < 12'sd8);
   assign text_row = glyph_row(tx[5:3], ty[2:0]);

   // Sprite layer: box end computed at 11 bits so a sprite near column 1023
   // is clipped rather than wrapped back to column 0.
   assign spr_x_end = {1'b0, sprite_x} + 11'd16;
   assign spr_y_end = {1'b0, sprite_y} + 11'd16;
   assign spr_in    = ({1'b0, x_pos} >= {1'b0, sprite_x}) && ({1'b0, x_pos} < spr_x_end) &&
                      ({1'b0, y_pos} >= {1'b0, sprite_y}) && ({1'b0, y_pos} < spr_y_end);
   assign spr_u     = 4'(x_pos - sprite_x);
   assign spr_v     = 4'(y_pos - sprite_y);

   // Cube layer: depth direction from rotation (x negative for 2,3; y
   // negative for 0,3).
   assign neg_x = rotation[1];
   assign neg_y = ~(rotation[1] ^ rotation[0]);
   assign ox    = neg_x ? -DD : DD;
   assign oy    = neg_y ? -DD : DD;

   always_comb begin
      text_d   = 1'b0;
      sprite_d = 1'b0;
      vector_d = 1'b0;
      pixel_d  = 1'b0;
      if (display_on) begin
         text_d   = text_in && text_row[~tx[2:0]];
         sprite_d = spr_in && diamond_hit(spr_u, spr_v);
         vector_d = on_outline(xs, ys, FL, FR, FT, FB) ||
                    on_outline(xs, ys, FL + ox, FR + ox, FT + oy, FB + oy) ||
                    on_connector(xs, ys, FL, FT, neg_x, neg_y, DD) ||
                    on_connector(xs, ys, FR, FT, neg_x, neg_y, DD) ||
                    on_connector(xs, ys, FL, FB, neg_x, neg_y, DD) ||
                    on_connector(xs, ys, FR, FB, neg_x, neg_y, DD);
         pixel_d  = text_d || sprite_d || vector_d;
      end
   end

   // ---- output register stage (latency 1) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         text_q   <= 1'b0;
         sprite_q <= 1'b0;
         vector_q <= 1'b0;
         pixel_q  <= 1'b0;
      end else begin
         text_q   <= text_d;
         sprite_q <= sprite_d;
         vector_q <= vector_d;
         pixel_q  <= pixel_d;
      end
   end

   assign text_pixel   = text_q;
   assign sprite_pixel = sprite_q;
   assign vector_pixel = vector_q;
   assign pixel_out    = pixel_q;

endmodule

// File: tb/tb_demo_layer_renderer.sv
// -----------------------------------------------------------------------------
// tb_demo_layer_renderer
//
// Self-checking bench for demo_layer_renderer: directed points on each layer,
// reset behaviour, a merged-mask sweep along a text row and randomized pixels,
// all compared against a behavioural model of the overlay rules.
// -----------------------------------------------------------------------------
module tb_demo_layer_renderer;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic       display_on;
   logic [9:0] sprite_x;
   logic [9:0] sprite_y;
   logic [1:0] rotation;
   logic       text_pixel;
   logic       sprite_pixel;
   logic       vector_pixel;
   logic       pixel_out;

   int n_chk  = 0;
   int n_pass = 0;
   logic [3:0] prev_exp = 4'h0;

   int font [5][8] = '{
      '{'h66, 'h66, 'h66, 'h7E, 'h66, 'h66, 'h66, 'h00},
      '{'h7E, 'h60, 'h60, 'h7C, 'h60, 'h60, 'h7E, 'h00},
      '{'h60, 'h60, 'h60, 'h60, 'h60, 'h60, 'h7E, 'h00},
      '{'h60, 'h60, 'h60, 'h60, 'h60, 'h60, 'h7E, 'h00},
      '{'h3C, 'h66, 'h66, 'h66, 'h66, 'h66, 'h3C, 'h00}
   };

   demo_layer_renderer dut (
      .clk          (clk),
      .rst          (rst),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .display_on   (display_on),
      .sprite_x     (sprite_x),
      .sprite_y     (sprite_y),
      .rotation     (rotation),
      .text_pixel   (text_pixel),
      .sprite_pixel (sprite_pixel),
      .vector_pixel (vector_pixel),
      .pixel_out    (pixel_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit sq_outline(int x, int y, int l, int r, int t, int b);
      return ((x == l || x == r) && y >= t && y <= b) ||
             ((y == t || y == b) && x >= l && x <= r);
   endfunction

   // Returns {pixel_out, vector, sprite, text}
   function automatic logic [3:0] model(int x, int y, bit disp, int spx, int spy, int rot);
      bit t, s, v;
      int ox, oy, sgx, sgy;
      t = 0; s = 0; v = 0;
      if (!disp) return 4'h0;
      if (x >= 16 && x < 56 && y >= 16 && y < 24) begin
         int c = x - 16;
         t = ((font[c / 8][y - 16] >> (7 - (c % 8))) & 1) != 0;
      end
      if (x >= spx && x < spx + 16 && y >= spy && y < spy + 16) begin
         int u = x - spx, w = y - spy, a, b;
         a = (u < 8) ? 7 - u : u - 8;
         b = (w < 8) ? 7 - w : w - 8;
         s = (a + b) <= 7;
      end
      ox = (rot == 0 || rot == 1) ? 16 : -16;
      oy = (rot == 1 || rot == 2) ? 16 : -16;
      sgx = (ox > 0) ? 1 : -1;
      sgy = (oy > 0) ? 1 : -1;
      v = sq_outline(x, y, 440, 520, 200, 280) ||
          sq_outline(x, y, 440 + ox, 520 + ox, 200 + oy, 280 + oy);
      for (int cx = 0; cx < 2; cx++)
         for (int cy = 0; cy < 2; cy++) begin
            int px = cx ? 520 : 440;
            int py = cy ? 280 : 200;
            int dx = (x - px) * sgx;
            int dy = (y - py) * sgy;
            if (dx == dy && dx >= 0 && dx <= 16) v = 1;
         end
      return {t | s | v, v, s, t};
   endfunction

   function automatic logic [3:0] outs();
      return {pixel_out, vector_pixel, sprite_pixel, text_pixel};
   endfunction

   // Called just after a rising edge: drives a pixel, confirms the outputs
   // still show the previous pixel before the edge, then checks the new one.
   task automatic step(input int x, input int y, input bit d, input int spx, input int spy,
                       input int rot, input string tag);
      logic [3:0] e;
      x_pos      = 10'(x);
      y_pos      = 10'(y);
      display_on = d;
      sprite_x   = 10'(spx);
      sprite_y   = 10'(spy);
      rotation   = 2'(rot);
      #2;
      chk({tag, "_hold"}, outs(), prev_exp);
      e = model(x, y, d, spx, spy, rot);
      @(posedge clk);
      #1;
      chk(tag, outs(), e);
      prev_exp = e;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; x_pos = 10'd17; y_pos = 10'd16; display_on = 1'b1;
      sprite_x = 10'd900; sprite_y = 10'd600; rotation = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", outs(), 4'h0);
      rst = 1'b0;
      prev_exp = 4'h0;
      step(17, 16, 1, 900, 600, 0, "rst_rel");
      chk("rst_rel_text", text_pixel, 1'b1);

      // asynchronous clear mid-line, held while asserted
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", outs(), 4'h0);
      @(posedge clk);
      #1;
      chk("rst_held", outs(), 4'h0);
      rst = 1'b0;
      prev_exp = 4'h0;
      step(17, 16, 1, 900, 600, 0, "rst_first");
      chk("rst_first_text", text_pixel, 1'b1);

      // text
      step(16, 16, 1, 900, 600, 0, "txt_16_16");  chk("txt_16_16_b", text_pixel, 1'b0);
      step(17, 16, 1, 900, 600, 0, "txt_17_16");  chk("txt_17_16_b", text_pixel, 1'b1);
      step(25, 19, 1, 900, 600, 0, "txt_e_row3"); chk("txt_e_row3_b", text_pixel, 1'b1);
      step(56, 16, 1, 900, 600, 0, "txt_out");    chk("txt_out_b", text_pixel, 1'b0);
      step(17, 16, 0, 900, 600, 0, "txt_disp0");  chk("txt_disp0_b", outs(), 4'h0);

      // sprite at (100,150)
      step(107, 150, 1, 100, 150, 0, "spr_top");    chk("spr_top_b", sprite_pixel, 1'b1);
      step(100, 150, 1, 100, 150, 0, "spr_corner"); chk("spr_corner_b", sprite_pixel, 1'b0);
      step(108, 157, 1, 100, 150, 0, "spr_mid");    chk("spr_mid_b", sprite_pixel, 1'b1);
      step(116, 150, 1, 100, 150, 0, "spr_right");  chk("spr_right_b", sprite_pixel, 1'b0);
      step(115, 158, 1, 100, 150, 0, "spr_115_158");
      step(115, 165, 1, 100, 150, 0, "spr_botright"); chk("spr_botright_b", sprite_pixel, 1'b0);
      step(1020, 5, 1, 1015, 0, 0, "spr_clip");

      // cube
      step(440, 200, 1, 900, 600, 0, "cub_corner"); chk("cub_corner_b", vector_pixel, 1'b1);
      step(480, 240, 1, 900, 600, 0, "cub_centre"); chk("cub_centre_b", vector_pixel, 1'b0);
      step(456, 230, 1, 900, 600, 0, "cub_back0");  chk("cub_back0_b", vector_pixel, 1'b1);
      step(456, 230, 1, 900, 600, 2, "cub_r2_old"); chk("cub_r2_old_b", vector_pixel, 1'b0);
      step(424, 230, 1, 900, 600, 2, "cub_r2_new"); chk("cub_r2_new_b", vector_pixel, 1'b1);
      step(448, 208, 1, 900, 600, 1, "con_on");     chk("con_on_b", vector_pixel, 1'b1);
      step(449, 208, 1, 900, 600, 1, "con_off");    chk("con_off_b", vector_pixel, 1'b0);
      step(457, 217, 1, 900, 600, 1, "con_beyond"); chk("con_beyond_b", vector_pixel, 1'b0);
      step(456, 216, 1, 900, 600, 1, "con_end");    chk("con_end_b", vector_pixel, 1'b1);

      // merged sweep along the text row with the sprite overlapping it
      for (int x = 0; x < 640; x++) begin
         step(x, 16, 1, 20, 16, 0, "sweep");
         chk("sweep_or", pixel_out, text_pixel | sprite_pixel | vector_pixel);
      end

      // randomized pixels biased towards the interesting regions
      for (int i = 0; i < 400; i++) begin
         int x, y, spx, spy, sel;
         sel = int'($urandom_range(0, 3));
         spx = int'($urandom_range(0, 1023));
         spy = int'($urandom_range(0, 1023));
         case (sel)
            0: begin x = int'($urandom_range(8, 64));    y = int'($urandom_range(8, 28));    end
            1: begin x = int'($urandom_range(410, 550)); y = int'($urandom_range(170, 310)); end
            2: begin
               spx = int'($urandom_range(0, 1023)); spy = int'($urandom_range(0, 1023));
               x = (spx + int'($urandom_range(0, 17)) - 1) & 1023;
               y = (spy + int'($urandom_range(0, 17)) - 1) & 1023;
            end
            default: begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
         endcase
         step(x, y, ($urandom_range(0, 9) != 0), spx, spy, int'($urandom_range(0, 3)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
